prim_subreg_ext_fifo: RTL and testbench
=======================================

PRIM_SUBREG_EXT_FIFO -- requirements
Module: prim_subreg_ext_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, data width matching the external register slice.
REQ-002 SHALL have parameter Depth, default 4, entries per FIFO, legal range 2..16.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port qe_i, input, 1, software write strobe from the register slice.
REQ-006 SHALL have port q_i, input, DW, software write data.
REQ-007 SHALL have port qre_i, input, 1, software read strobe from the register slice.
REQ-008 SHALL have port d_o, output, DW, read data returned to the register slice.
REQ-009 SHALL have ports tx_valid_o (output, 1), tx_ready_i (input, 1) and tx_data_o (output, DW), forming the hardware-side drain of software writes.
REQ-010 SHALL have ports rx_valid_i (input, 1), rx_ready_o (output, 1) and rx_data_i (input, DW), forming the hardware-side fill for software reads.
REQ-011 SHALL have port clr_i, input, 1, which clears the sticky error flags.
REQ-012 SHALL have port status_o, output, status_t, carrying tx_cnt, rx_cnt, tx_overflow and rx_underflow.

Function
REQ-013 SHALL push q_i into the TX FIFO when qe_i is high and the TX FIFO is not full, or is full but pops in the same cycle.
REQ-014 SHALL drop a qe_i push when the TX FIFO is full with no simultaneous pop, and SHALL set tx_overflow.
REQ-015 SHALL assert tx_valid_o whenever the TX FIFO is non-empty, with tx_data_o equal to the head entry; a pushed word is visible one cycle after qe_i.
REQ-016 SHALL pop the TX FIFO when tx_valid_o and tx_ready_i are both high; tx_data_o and tx_valid_o SHALL hold stable while tx_ready_i is low.
REQ-017 SHALL drive rx_ready_o high when the RX FIFO is not full or is being popped by qre_i in that cycle, and SHALL push rx_data_i on rx_valid_i & rx_ready_o.
REQ-018 SHALL drive d_o combinationally from the RX FIFO head when it is non-empty, and SHALL drive 0 when it is empty.
REQ-019 SHALL pop the RX FIFO on qre_i when it is non-empty; d_o in the qre_i cycle SHALL be the popped word.
REQ-020 SHALL set rx_underflow on qre_i when the RX FIFO is empty, leaving the FIFO state unchanged.
REQ-021 SHALL let a simultaneous push and pop on the same FIFO leave the count unchanged and preserve FIFO order, including at empty (write-through is forbidden: data appears one cycle later) and at full.
REQ-022 SHALL size the counts at $clog2(Depth+1) bits; the read and write pointers SHALL wrap from Depth-1 to 0.
REQ-023 SHALL keep the sticky flags set until clr_i; if clr_i coincides with a new error event, the flag SHALL stay set.

Reset
REQ-024 SHALL, on rst_i, zero both pointer sets, both counts and both sticky flags in the next cycle; tx_valid_o=0, rx_ready_o=1 and d_o=0 after reset.
REQ-025 SHALL give rst_i priority over every simultaneous qe_i, qre_i and handshake; FIFO contents SHALL need no reset.

Structure
REQ-026 SHALL define status_t (packed: tx_cnt, rx_cnt, tx_overflow, rx_underflow) and a MaxDepth=16 constant in package prim_subreg_ext_fifo_pkg.
REQ-027 SHALL instantiate the sub-module prim_subreg_ext_fifo_core (synchronous FIFO with count, full, empty and head outputs) twice, once for TX and once for RX.

Verification
REQ-028 SHALL cover: qe_i with q_i=0xA5A5_0001 while tx_ready_i=0 -> tx_valid_o=1 and tx_data_o=0xA5A5_0001 the next cycle, held stable until tx_ready_i=1.
REQ-029 SHALL cover: five qe_i writes with Depth=4 and tx_ready_i=0 -> tx_cnt=4, tx_overflow=1, and drain order equals words 1-4.
REQ-030 SHALL cover: qre_i with the RX FIFO empty -> d_o=0, rx_underflow=1; then clr_i -> rx_underflow=0.
REQ-031 SHALL cover: RX FIFO full (rx_cnt=4), qre_i and rx_valid_i in the same cycle -> rx_ready_o=1, rx_cnt stays 4, order preserved.
REQ-032 SHALL cover: rst_i asserted mid-stream with tx_cnt=3 and qe_i high -> next cycle tx_cnt=0, tx_valid_o=0, flags=0.

Source files
------------

// File: rtl/prim_subreg_ext_fifo_pkg.sv
// Shared types and constants for the external-register FIFO pair.
package prim_subreg_ext_fifo_pkg;

    localparam int MaxDepth   = 16;
    localparam int StatusCntW = $clog2(MaxDepth + 1);

    // Counts are sized for the largest legal depth so the status layout never changes.
    typedef struct packed {
        logic [StatusCntW-1:0] tx_cnt;
        logic [StatusCntW-1:0] rx_cnt;
        logic                  tx_overflow;
        logic                  rx_underflow;
    } status_t;

endpackage

// File: rtl/prim_subreg_ext_fifo_core.sv
// Synchronous FIFO with occupancy count; push/pop arrive already qualified by the caller.
module prim_subreg_ext_fifo_core
    import prim_subreg_ext_fifo_pkg::*;
#(
    parameter int DW    = 32,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic            pop,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   head,
    output logic [CntW-1:0] cnt,
    output logic            full,
    output logic            empty
);

    logic [DW-1:0]   mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= ptr_next(wptr);
            if (pop)  rptr <= ptr_next(rptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never reset; pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata;
    end

    assign head  = mem[rptr];
    assign full  = (cnt == CntW'(Depth));
    assign empty = (cnt == '0);

endmodule

// File: rtl/prim_subreg_ext_fifo.sv
// Decouples a software register slice from hardware: TX drains SW writes, RX feeds SW reads.
module prim_subreg_ext_fifo
    import prim_subreg_ext_fifo_pkg::*;
#(
    parameter int DW    = 32,
    parameter int Depth = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          qe_i,
    input  logic [DW-1:0] q_i,
    input  logic          qre_i,
    output logic [DW-1:0] d_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic [DW-1:0] tx_data_o,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    input  logic [DW-1:0] rx_data_i,
    input  logic          clr_i,
    output status_t       status_o
);

    localparam int CntW = $clog2(Depth + 1);

    logic [DW-1:0]   tx_head, rx_head;
    logic [CntW-1:0] tx_cnt, rx_cnt;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push, tx_pop, rx_push, rx_pop;
    logic            tx_ovf_evt, rx_udf_evt;
    logic            tx_overflow, rx_underflow;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign tx_pop     = !tx_empty && tx_ready_i;
    assign tx_push    = qe_i && (!tx_full || tx_pop);
    assign tx_ovf_evt = qe_i && tx_full && !tx_pop;

    assign rx_pop     = qre_i && !rx_empty;
    assign rx_ready_o = !rx_full || rx_pop;
    assign rx_push    = rx_valid_i && rx_ready_o;
    assign rx_udf_evt = qre_i && rx_empty;

    prim_subreg_ext_fifo_core #(.DW(DW), .Depth(Depth)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (q_i),
        .head  (tx_head),
        .cnt   (tx_cnt),
        .full  (tx_full),
        .empty (tx_empty)
    );

    prim_subreg_ext_fifo_core #(.DW(DW), .Depth(Depth)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data_i),
        .head  (rx_head),
        .cnt   (rx_cnt),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // A new error event wins over a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (tx_ovf_evt)  tx_overflow <= 1'b1;
            else if (clr_i)  tx_overflow <= 1'b0;
            if (rx_udf_evt)  rx_underflow <= 1'b1;
            else if (clr_i)  rx_underflow <= 1'b0;
        end
    end

    assign tx_valid_o = !tx_empty;
    assign tx_data_o  = tx_head;
    assign d_o        = rx_empty ? '0 : rx_head;

    assign status_o.tx_cnt       = StatusCntW'(tx_cnt);
    assign status_o.rx_cnt       = StatusCntW'(rx_cnt);
    assign status_o.tx_overflow  = tx_overflow;
    assign status_o.rx_underflow = rx_underflow;

endmodule

// File: tb/tb_prim_subreg_ext_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_prim_subreg_ext_fifo;
    import prim_subreg_ext_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int Depth = 4;

    logic          clk = 1'b0;
    logic          rst, qe, qre, tx_ready, rx_valid, clr;
    logic [DW-1:0] q, rx_data;
    logic [DW-1:0] d, tx_data;
    logic          tx_valid, rx_ready;
    status_t       status;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    logic          m_ovf, m_udf;

    always #5 clk = ~clk;

    prim_subreg_ext_fifo #(.DW(DW), .Depth(Depth)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .qe_i       (qe),
        .q_i        (q),
        .qre_i      (qre),
        .d_o        (d),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .rx_data_i  (rx_data),
        .clr_i      (clr),
        .status_o   (status)
    );

    // Reference behaviour of one clock edge, from the current inputs and queue state.
    task automatic model_edge();
        bit tpop, tpush, rpop, rpush, ovf_evt, udf_evt;
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            tpop    = (txq.size() > 0) && tx_ready;
            tpush   = qe && ((txq.size() < Depth) || tpop);
            ovf_evt = qe && !tpush;
            rpop    = qre && (rxq.size() > 0);
            rpush   = rx_valid && ((rxq.size() < Depth) || rpop);
            udf_evt = qre && (rxq.size() == 0);
            if (tpop)  void'(txq.pop_front());
            if (tpush) txq.push_back(q);
            if (rpop)  void'(rxq.pop_front());
            if (rpush) rxq.push_back(rx_data);
            if (ovf_evt)  m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (udf_evt)  m_udf = 1'b1;
            else if (clr) m_udf = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        qe = 0; qre = 0; tx_ready = 0; rx_valid = 0; clr = 0;
        q = '0; rx_data = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %0h expected 0", tx_valid); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %0h expected 1", rx_ready); end
        total++; if (d !== '0) begin bad++; $display("FAIL reset_d: got %0h expected 0", d); end
        total++; if (status !== '0) begin bad++; $display("FAIL reset_status: got %0h expected 0", status); end
    endtask

    task automatic test_tx_hold();
        qe = 1; q = 32'hA5A5_0001; tx_ready = 0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_no_write_through: got %0h expected 0", tx_valid); end
        tick();
        qe = 0; q = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_hold_valid: got %0h expected 1", tx_valid); end
            total++; if (tx_data !== 32'hA5A5_0001) begin bad++; $display("FAIL tx_hold_data: got %0h expected a5a50001", tx_data); end
            tick();
        end
        tx_ready = 1;
        tick();
        tx_ready = 0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained_valid: got %0h expected 0", tx_valid); end
        total++; if (status.tx_cnt !== StatusCntW'(0)) begin bad++; $display("FAIL tx_drained_cnt: got %0d expected 0", status.tx_cnt); end
    endtask

    task automatic test_tx_overflow();
        tx_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            qe = 1; q = 32'h1000 + i;
            tick();
        end
        qe = 0;
        #1;
        total++; if (status.tx_cnt !== StatusCntW'(4)) begin bad++; $display("FAIL ovf_cnt: got %0d expected 4", status.tx_cnt); end
        total++; if (status.tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0h expected 1", status.tx_overflow); end
        tx_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if (tx_data !== DW'(32'h1000 + i)) begin bad++; $display("FAIL ovf_drain_order: got %0h expected %0h", tx_data, 32'h1000 + i); end
            tick();
        end
        tx_ready = 0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_empty: got %0h expected 0", tx_valid); end
        total++; if (status.tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0h expected 1", status.tx_overflow); end
        clr = 1;
        tick();
        clr = 0;
        #1;
        total++; if (status.tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0h expected 0", status.tx_overflow); end
    endtask

    task automatic test_rx_underflow();
        qre = 1;
        #1;
        total++; if (d !== '0) begin bad++; $display("FAIL udf_d: got %0h expected 0", d); end
        tick();
        qre = 0;
        #1;
        total++; if (status.rx_underflow !== 1'b1) begin bad++; $display("FAIL udf_flag: got %0h expected 1", status.rx_underflow); end
        total++; if (status.rx_cnt !== StatusCntW'(0)) begin bad++; $display("FAIL udf_cnt: got %0d expected 0", status.rx_cnt); end
        qre = 1; clr = 1;
        tick();
        qre = 0; clr = 0;
        #1;
        total++; if (status.rx_underflow !== 1'b1) begin bad++; $display("FAIL udf_clr_vs_event: got %0h expected 1", status.rx_underflow); end
        clr = 1;
        tick();
        clr = 0;
        #1;
        total++; if (status.rx_underflow !== 1'b0) begin bad++; $display("FAIL udf_clr: got %0h expected 0", status.rx_underflow); end
    endtask

    task automatic test_rx_full_simul();
        logic [DW-1:0] words [5];
        for (int i = 0; i < 5; i++) words[i] = 32'h5000_0000 | $urandom_range(0, 16'hFFFF);
        rx_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rx_data = words[i];
            tick();
        end
        rx_valid = 0;
        #1;
        total++; if (status.rx_cnt !== StatusCntW'(4)) begin bad++; $display("FAIL rxfull_cnt: got %0d expected 4", status.rx_cnt); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rxfull_ready: got %0h expected 0", rx_ready); end
        rx_valid = 1; rx_data = words[4]; qre = 1;
        #1;
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rxfull_simul_ready: got %0h expected 1", rx_ready); end
        total++; if (d !== words[0]) begin bad++; $display("FAIL rxfull_simul_d: got %0h expected %0h", d, words[0]); end
        tick();
        rx_valid = 0; qre = 0;
        #1;
        total++; if (status.rx_cnt !== StatusCntW'(4)) begin bad++; $display("FAIL rxfull_simul_cnt: got %0d expected 4", status.rx_cnt); end
        qre = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if (d !== words[i]) begin bad++; $display("FAIL rxfull_order: got %0h expected %0h", d, words[i]); end
            tick();
        end
        qre = 0;
        #1;
        total++; if (d !== '0) begin bad++; $display("FAIL rxfull_empty_d: got %0h expected 0", d); end
        total++; if (status.rx_underflow !== 1'b0) begin bad++; $display("FAIL rxfull_no_udf: got %0h expected 0", status.rx_underflow); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        logic          exp_ready;
        for (int n = 0; n < 400; n++) begin
            qe       = ($urandom_range(0, 99) < 50);
            q        = $urandom;
            qre      = ($urandom_range(0, 99) < 40);
            tx_ready = ($urandom_range(0, 99) < 45);
            rx_valid = ($urandom_range(0, 99) < 50);
            rx_data  = $urandom;
            clr      = ($urandom_range(0, 99) < 8);
            #1;
            exp_d     = (rxq.size() > 0) ? rxq[0] : '0;
            exp_ready = (rxq.size() < Depth) || (qre && rxq.size() > 0);
            total++; if (tx_valid !== (txq.size() > 0)) begin bad++; $display("FAIL rnd_tx_valid: got %0h expected %0h", tx_valid, txq.size() > 0); end
            if (txq.size() > 0) begin
                total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL rnd_tx_data: got %0h expected %0h", tx_data, txq[0]); end
            end
            total++; if (d !== exp_d) begin bad++; $display("FAIL rnd_d: got %0h expected %0h", d, exp_d); end
            total++; if (rx_ready !== exp_ready) begin bad++; $display("FAIL rnd_rx_ready: got %0h expected %0h", rx_ready, exp_ready); end
            total++; if (status.tx_cnt !== StatusCntW'(txq.size())) begin bad++; $display("FAIL rnd_tx_cnt: got %0d expected %0d", status.tx_cnt, txq.size()); end
            total++; if (status.rx_cnt !== StatusCntW'(rxq.size())) begin bad++; $display("FAIL rnd_rx_cnt: got %0d expected %0d", status.rx_cnt, rxq.size()); end
            total++; if (status.tx_overflow !== m_ovf) begin bad++; $display("FAIL rnd_tx_ovf: got %0h expected %0h", status.tx_overflow, m_ovf); end
            total++; if (status.rx_underflow !== m_udf) begin bad++; $display("FAIL rnd_rx_udf: got %0h expected %0h", status.rx_underflow, m_udf); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_rst_midstream();
        do_reset();
        qre = 1;
        tick();
        qre = 0; tx_ready = 0;
        for (int i = 0; i < 3; i++) begin
            qe = 1; q = 32'h7000 + i;
            tick();
        end
        #1;
        total++; if (status.tx_cnt !== StatusCntW'(3)) begin bad++; $display("FAIL rstmid_pre_cnt: got %0d expected 3", status.tx_cnt); end
        total++; if (status.rx_underflow !== 1'b1) begin bad++; $display("FAIL rstmid_pre_flag: got %0h expected 1", status.rx_underflow); end
        qe = 1; q = 32'h7777; qre = 1; rx_valid = 1; tx_ready = 1; rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        #1;
        total++; if (status.tx_cnt !== StatusCntW'(0)) begin bad++; $display("FAIL rstmid_cnt: got %0d expected 0", status.tx_cnt); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_tx_valid: got %0h expected 0", tx_valid); end
        total++; if (status !== '0) begin bad++; $display("FAIL rstmid_status: got %0h expected 0", status); end
        total++; if (rx_ready !== 1'b1 || d !== '0) begin bad++; $display("FAIL rstmid_rx: got ready=%0h d=%0h expected ready=1 d=0", rx_ready, d); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_ovf = 0;
        m_udf = 0;
        test_reset();
        test_tx_hold();
        test_tx_overflow();
        test_rx_underflow();
        test_rx_full_simul();
        do_reset();
        test_random();
        test_rst_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
